// File: rtl/axioma_irq_pkg.sv
// Shared definitions for the Timer2 interrupt block: flag bit positions, vector
// numbers, request FSM encoding and the fixed-priority source picker.
package axioma_irq_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] BIT_TOV2  = 2'd0;
  localparam logic [1:0] BIT_OCF2A = 2'd1;
  localparam logic [1:0] BIT_OCF2B = 2'd2;

  localparam logic [4:0] VEC_COMPA = 5'd7;
  localparam logic [4:0] VEC_COMPB = 5'd8;
  localparam logic [4:0] VEC_OVF   = 5'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACKED = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] src;
    logic [4:0] vec;
  } irq_pick_t;

  // Priority OCF2A > OCF2B > TOV2 over the enabled, pending flags.
  function automatic irq_pick_t irq_pick(input logic [NUM_SRC-1:0] pend);
    irq_pick_t p;
    p = '0;
    if (pend[BIT_OCF2A])      p = '{hit: 1'b1, src: BIT_OCF2A, vec: VEC_COMPA};
    else if (pend[BIT_OCF2B]) p = '{hit: 1'b1, src: BIT_OCF2B, vec: VEC_COMPB};
    else if (pend[BIT_TOV2])  p = '{hit: 1'b1, src: BIT_TOV2,  vec: VEC_OVF};
    return p;
  endfunction

endpackage

// File: rtl/axioma_sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge detector for one
// Timer2 event line.
module axioma_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic evt,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   prev;
  logic                   armed;

  // vld_pipe marks which sync stages hold post-reset samples; the detector only
  // arms after a genuine low, so a line held high across reset never fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      vld_pipe <= '0;
      prev     <= 1'b0;
      armed    <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], evt};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      prev     <= sync[SYNC_STAGES-1];
      if (vld_pipe[SYNC_STAGES-1] && !sync[SYNC_STAGES-1]) armed <= 1'b1;
      pulse    <= sync[SYNC_STAGES-1] & ~prev & armed;
    end
  end

endmodule

// File: rtl/axioma_timer2_irq.sv
// Timer2 interrupt flags (TIFR2), mask (TIMSK2) and the single-request
// handshake FSM toward the CPU.
module axioma_timer2_irq
  import axioma_irq_pkg::*;
#(
  parameter logic [5:0] ADDR_TIFR2  = 6'h37,
  parameter logic [5:0] ADDR_TIMSK2 = 6'h38,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] io_addr,
  input  logic [7:0] io_data_in,
  output logic [7:0] io_data_out,
  input  logic       io_read,
  input  logic       io_write,
  input  logic       evt_compa,
  input  logic       evt_compb,
  input  logic       evt_ovf,
  output logic       irq_req,
  output logic [4:0] irq_vector,
  input  logic       irq_ack,
  output logic [2:0] debug_flags
);

  logic [NUM_SRC-1:0] evt_vec;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] tifr;
  logic [NUM_SRC-1:0] timsk;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] sw_clr;
  logic [NUM_SRC-1:0] ack_clr;
  logic               wr_tifr;
  logic               wr_timsk;
  logic               latch;
  logic               unused_bits;
  irq_pick_t          pick;
  irq_state_e         state, state_nx;
  logic [1:0]         src_q;
  logic [4:0]         vec_q;

  // Lane index equals the TIFR2 bit each event sets.
  assign evt_vec = {evt_compb, evt_compa, evt_ovf};

  axioma_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_SRC-1:0] (
    .clk   (clk),
    .reset (reset),
    .evt   (evt_vec),
    .pulse (set_vec)
  );

  assign wr_tifr     = io_write && (io_addr == ADDR_TIFR2);
  assign wr_timsk    = io_write && (io_addr == ADDR_TIMSK2);
  assign unused_bits = ^io_data_in[7:3];

  assign pend    = tifr & timsk;
  assign pick    = irq_pick(pend);
  assign sw_clr  = wr_tifr ? io_data_in[NUM_SRC-1:0] : '0;
  assign ack_clr = (state == ST_REQ && irq_ack) ? (3'b001 << src_q) : '0;

  // Sets are OR-ed in after clears so a coincident set always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tifr  <= '0;
      timsk <= '0;
    end else begin
      tifr <= (tifr & ~(sw_clr | ack_clr)) | set_vec;
      if (wr_timsk) timsk <= io_data_in[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      src_q <= '0;
      vec_q <= '0;
    end else begin
      state <= state_nx;
      if (latch) begin
        src_q <= pick.src;
        vec_q <= pick.vec;
      end
    end
  end

  // ACKED arbitrates itself so the request gap after an ack is one cycle.
  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick.hit) begin
          state_nx = ST_REQ;
          latch    = 1'b1;
        end
      end
      ST_REQ: begin
        if (irq_ack)           state_nx = ST_ACKED;
        else if (!pend[src_q]) state_nx = ST_IDLE;
      end
      ST_ACKED: begin
        state_nx = pick.hit ? ST_REQ : ST_IDLE;
        latch    = pick.hit;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign irq_req     = (state == ST_REQ);
  assign irq_vector  = irq_req ? vec_q : 5'd0;
  assign debug_flags = tifr;

  always_comb begin
    io_data_out = 8'h00;
    if (io_read) begin
      if (io_addr == ADDR_TIFR2)       io_data_out = {5'b0, tifr};
      else if (io_addr == ADDR_TIMSK2) io_data_out = {5'b0, timsk};
    end
  end

endmodule

// File: tb/tb_axioma_timer2_irq.sv
// Randomized and directed bench for axioma_timer2_irq with a vector scoreboard
// fed by the stimulus and drained by an independent monitor.
module tb_axioma_timer2_irq;

  localparam logic [5:0] A_TIFR  = 6'h37;
  localparam logic [5:0] A_TIMSK = 6'h38;

  logic       clk, reset;
  logic [5:0] io_addr;
  logic [7:0] io_data_in, io_data_out;
  logic       io_read, io_write;
  logic       evt_compa, evt_compb, evt_ovf;
  logic       irq_req, irq_ack;
  logic [4:0] irq_vector;
  logic [2:0] debug_flags;

  int errs = 0;
  int checks = 0;
  int exp_q[$];
  int man_req = 0;
  int man_seen = 0;
  bit auto_ack = 0;

  axioma_timer2_irq #(.ADDR_TIFR2(6'h37), .ADDR_TIMSK2(6'h38), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_data_in(io_data_in),
    .io_data_out(io_data_out), .io_read(io_read), .io_write(io_write),
    .evt_compa(evt_compa), .evt_compb(evt_compb), .evt_ovf(evt_ovf),
    .irq_req(irq_req), .irq_vector(irq_vector), .irq_ack(irq_ack),
    .debug_flags(debug_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_data_in = d; io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    io_addr = a; io_read = 1'b1;
    #1;
    d = io_data_out;
    io_read = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (irq_req) seen = 1;
      else @(negedge clk);
    end
    chk(name, seen, 1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (i > 8 && exp_q.size() == 0 && !irq_req) done = 1;
    end
    chk(name, done, 1);
  endtask

  // Acknowledge driver: manual one-shot acks or automatic acks with random delay.
  initial begin
    int dly;
    dly = 0;
    irq_ack = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      irq_ack = 1'b0;
      if (man_req != man_seen) begin
        man_seen = man_req;
        irq_ack = 1'b1;
      end else if (auto_ack && irq_req) begin
        if (dly == 0) begin
          irq_ack = 1'b1;
          dly = $urandom_range(0, 3);
        end else dly--;
      end
    end
  end

  // Monitor: each new request must carry the next expected vector.
  initial begin
    logic prev;
    int cur;
    prev = 1'b0;
    cur = 0;
    forever begin
      @(negedge clk);
      if (irq_req && !prev) begin
        if (exp_q.size() == 0) chk("irq_unexpected_vec", irq_vector, 0);
        else begin
          cur = exp_q.pop_front();
          chk("irq_vec", irq_vector, cur);
        end
      end else if (irq_req) chk("irq_vec_stable", irq_vector, cur);
      else chk("irq_vec_idle", irq_vector, 0);
      prev = irq_req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [2:0] subset, mask;
    int w;
    reset = 1'b1; io_addr = '0; io_data_in = '0; io_read = 0; io_write = 0;
    evt_compa = 0; evt_compb = 0; evt_ovf = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_irq_req", irq_req, 0);
    chk("rst_flags", debug_flags, 0);
    chk("rst_dout_noread", io_data_out, 0);
    rd(A_TIFR, d);  chk("rst_tifr", d, 0);
    rd(A_TIMSK, d); chk("rst_timsk", d, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Long overflow level: one flag, request four edges after the flag path
    wr(A_TIFR, 8'h07); wr(A_TIMSK, 8'h01);
    exp_q.push_back(9);
    evt_ovf = 1;
    repeat (3) @(negedge clk);
    chk("tov2_not_yet", debug_flags[0], 0);
    @(negedge clk);
    chk("tov2_set_n3", debug_flags[0], 1);
    chk("irq_low_n3", irq_req, 0);
    @(negedge clk);
    chk("irq_rise_n4", irq_req, 1);
    chk("irq_vec9_n4", irq_vector, 9);
    repeat (495) @(negedge clk);
    chk("tov2_held", debug_flags, 3'b001);
    chk("irq_held", irq_req, 1);
    man_req++;
    @(negedge clk);
    chk("ack_irq_low", irq_req, 0);
    chk("ack_tov2_clr", debug_flags[0], 0);
    repeat (20) @(negedge clk);
    chk("level_sets_once", debug_flags[0], 0);
    evt_ovf = 0;

    // Simultaneous compare-A and overflow: priority and single gap cycle
    wr(A_TIFR, 8'h07); wr(A_TIMSK, 8'h03);
    exp_q.push_back(7); exp_q.push_back(9);
    evt_compa = 1; evt_ovf = 1;
    @(negedge clk);
    evt_compa = 0; evt_ovf = 0;
    wait_irq("irq_wait_a");
    chk("prio_vec7", irq_vector, 7);
    man_req++;
    @(negedge clk);
    chk("gap_low", irq_req, 0);
    @(negedge clk);
    chk("rearb_high", irq_req, 1);
    chk("rearb_vec9", irq_vector, 9);
    man_req++;
    @(negedge clk);
    chk("second_ack_low", irq_req, 0);
    chk("all_flags_clr", debug_flags, 0);

    // Clear write colliding with a new set: set wins; W0 has no effect
    wr(A_TIMSK, 8'h00); wr(A_TIFR, 8'h07);
    evt_ovf = 1;
    repeat (3) @(negedge clk);
    chk("coll_pre", debug_flags[0], 0);
    io_addr = A_TIFR; io_data_in = 8'h01; io_write = 1;
    @(negedge clk);
    io_write = 0;
    chk("coll_set_wins", debug_flags[0], 1);
    rd(A_TIFR, d); chk("coll_tifr", d, 8'h01);
    wr(A_TIFR, 8'hFE); rd(A_TIFR, d); chk("w0_no_effect", d, 8'h01);
    wr(A_TIFR, 8'h01); rd(A_TIFR, d); chk("w1_clears", d, 8'h00);
    evt_ovf = 0;
    wr(A_TIMSK, 8'hFD); rd(A_TIMSK, d); chk("timsk_upper_zero", d, 8'h05);
    rd(6'h10, d); chk("unmapped_read", d, 0);

    // Mask removal during a compare-B request
    wr(A_TIMSK, 8'h04); wr(A_TIFR, 8'h07);
    exp_q.push_back(8);
    evt_compb = 1;
    @(negedge clk);
    evt_compb = 0;
    wait_irq("irq_wait_b");
    chk("vec8", irq_vector, 8);
    wr(A_TIMSK, 8'h00);
    @(negedge clk);
    chk("withdraw", irq_req, 0);
    rd(A_TIFR, d); chk("ocf2b_kept", d, 8'h04);

    // Reset during request; held-high input must not fire after release
    exp_q.push_back(8);
    wr(A_TIMSK, 8'h04);
    wait_irq("irq_wait_rst");
    evt_compa = 1;
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst_mid_req", irq_req, 0);
    chk("rst_mid_vec", irq_vector, 0);
    chk("rst_mid_flags", debug_flags, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    rd(A_TIFR, d);  chk("post_rst_tifr", d, 0);
    rd(A_TIMSK, d); chk("post_rst_timsk", d, 0);
    repeat (10) @(negedge clk);
    chk("held_high_no_set", debug_flags, 0);
    evt_compa = 0;
    repeat (5) @(negedge clk);
    evt_compa = 1;
    repeat (6) @(negedge clk);
    chk("rearmed_set", debug_flags, 3'b010);
    evt_compa = 0;
    wr(A_TIFR, 8'h07);

    // Random batches: model = enabled flags served in priority order, rest left set
    auto_ack = 1;
    for (int b = 0; b < 25; b++) begin
      subset = 3'($urandom_range(1, 7));
      mask   = 3'($urandom_range(0, 7));
      wr(A_TIFR, 8'h07);
      wr(A_TIMSK, {5'b0, mask});
      if (subset[1] && mask[1]) exp_q.push_back(7);
      if (subset[2] && mask[2]) exp_q.push_back(8);
      if (subset[0] && mask[0]) exp_q.push_back(9);
      {evt_compb, evt_compa, evt_ovf} = subset;
      w = $urandom_range(1, 4);
      repeat (w) @(negedge clk);
      {evt_compb, evt_compa, evt_ovf} = 3'b000;
      drain("rand_drain");
      rd(A_TIFR, d);
      chk("rand_tifr", d, {5'b0, subset & ~mask});
    end
    auto_ack = 0;

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/axioma_timer2_irq.md
AXIOMA_TIMER2_IRQ -- requirements
Module: axioma_timer2_irq

Interface
REQ-001 SHALL have parameter ADDR_TIFR2, default 6'h37: I/O address of the interrupt flag register.
REQ-002 SHALL have parameter ADDR_TIMSK2, default 6'h38: I/O address of the interrupt mask register.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal range 2..3: synchronizer depth on the event inputs.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port io_addr, input, 6 bits: I/O address.
REQ-007 SHALL have port io_data_in, input, 8 bits: write data.
REQ-008 SHALL have port io_data_out, output, 8 bits: read data.
REQ-009 SHALL have ports io_read and io_write, inputs, 1 bit each: read and write strobes.
REQ-010 SHALL have ports evt_compa, evt_compb and evt_ovf, inputs, 1 bit each: compare-A, compare-B and overflow events from Timer2, possibly generated in the 32.768 kHz domain.
REQ-011 SHALL have port irq_req, output, 1 bit: interrupt request to the CPU.
REQ-012 SHALL have port irq_vector, output, 5 bits: vector number of the requested interrupt.
REQ-013 SHALL have port irq_ack, input, 1 bit: single-cycle acknowledge from the CPU.
REQ-014 SHALL have port debug_flags, output, 3 bits: live TIFR2 flag bits [2:0].

Function
REQ-015 SHALL pass each evt_* input through SYNC_STAGES flops, then a rising-edge detector; a level held high for many clk cycles sets its flag once.
REQ-016 SHALL map TIFR2 as: bit2 = OCF2B, bit1 = OCF2A, bit0 = TOV2; TIMSK2 as: bit2 = OCIE2B, bit1 = OCIE2A, bit0 = TOIE2; bits 7:3 of both read 0 and ignore writes.
REQ-017 SHALL set a flag in the cycle after its synchronized edge is detected; with SYNC_STAGES=2, an input rising before edge N is visible in debug_flags after edge N+3.
REQ-018 SHALL clear a TIFR2 flag when software writes 1 to its bit; writing 0 has no effect.
REQ-019 SHALL give set priority when a set and a clear (software or ack) hit the same flag in the same cycle: the flag ends set.
REQ-020 SHALL load TIMSK2[2:0] from io_data_in on a write.
REQ-021 SHALL drive io_data_out combinationally with the addressed register when io_read is high and the address matches, else 8'h00.
REQ-022 SHALL run the request FSM with states IDLE, REQ and ACKED.
REQ-023 IDLE: if any (flags & mask) bit is set, SHALL latch the highest-priority source (OCF2A > OCF2B > TOV2) and enter REQ the next cycle.
REQ-024 REQ: SHALL hold irq_req = 1 with irq_vector stable at the latched value: 7 = COMPA, 8 = COMPB, 9 = OVF.
REQ-025 REQ with irq_ack: SHALL clear the latched source's flag (subject to REQ-019) and enter ACKED.
REQ-026 REQ with the latched flag or its mask bit cleared (no ack): SHALL withdraw irq_req and return to IDLE the next cycle.
REQ-027 ACKED: SHALL hold irq_req low for exactly one cycle, then return to IDLE and re-arbitrate.
REQ-028 SHALL ignore irq_ack in IDLE and ACKED.
REQ-029 SHALL drive irq_vector to 0 whenever irq_req is 0.
REQ-030 SHALL assert irq_req exactly when the state is REQ (registered output).

Reset
REQ-031 Reset SHALL asynchronously clear the synchronizers, edge registers, TIFR2 and TIMSK2 to 0, put the FSM in IDLE, and force irq_req = 0, irq_vector = 0 and debug_flags = 0; io_data_out is 0 unless a read is active.
REQ-032 Reset asserted mid-REQ SHALL drop irq_req in the same cycle, without an ack.
REQ-033 A synchronized input still high at reset release SHALL NOT set its flag until it has gone low and risen again.

Structure
REQ-034 SHALL place the flag bit indices, the vector numbers (7/8/9) and the FSM state encodings in a shared package, axioma_irq_pkg.
REQ-035 SHALL implement the synchronizer plus edge detector as one sub-module, axioma_sync_edge, instantiated three times.

Verification
REQ-036 Hold evt_ovf high for 500 cycles with TOIE2=1 -> TOV2 is set once; irq_req rises on cycle 4 with vector 9; ack -> TOV2=0 and irq_req low.
REQ-037 Pulse evt_compa and evt_ovf in the same cycle with both enabled -> vector 7 first; after ack, one low cycle, then vector 9.
REQ-038 Write TIFR2=8'h01 on the same cycle a new TOV2 edge sets -> TOV2 stays 1.
REQ-039 In REQ (vector 8), write TIMSK2=8'h00 -> irq_req drops the next cycle; OCF2B remains 1 and reads back as TIFR2=8'h04.
REQ-040 Assert reset while irq_req=1 -> irq_req=0 immediately; after release, reading TIFR2 and TIMSK2 returns 8'h00.
